// File: rtl/ffd_pipe_pkg.sv
// Shared defaults and helpers for the ffd_pipe elastic register pipeline.
package ffd_pipe_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 3;
  localparam int DEF_RESET_VAL = 0;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ffd_pipe_stage.sv
// One elastic stage: valid bit plus data word, refilled from upstream whenever
// this stage is empty or its word is leaving.
module ffd_pipe_stage
  import ffd_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_rdy,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  logic rdy, take, leave;

  assign rdy   = ~v | dn_rdy;
  assign take  = up_valid & rdy;
  assign leave = v & dn_rdy;

  // Data only loads on a real transfer, so an idle X on the input never lands here.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else if (flush) begin
      v <= 1'b0;
    end else if (take) begin
      v <= 1'b1;
      d <= up_data;
    end else if (leave) begin
      v <= 1'b0;
    end
  end

endmodule

// File: rtl/ffd_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready on both sides,
// bubble collapsing, synchronous flush and a registered occupancy count.
module ffd_pipe
  import ffd_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL),
  localparam int              CW        = clog2(DEPTH + 1)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0]            v, up_v;
  logic [DEPTH-1:0][WIDTH-1:0] d, up_d;
  logic [DEPTH:0]              r;
  logic                        in_acc, out_acc;

  assign up_v[0] = in_valid & ~flush;
  assign up_d[0] = in_data;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i > 0) begin : g_link
      assign up_v[i] = v[i-1];
      assign up_d[i] = d[i-1];
    end
    ffd_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (up_v[i]),
      .up_data  (up_d[i]),
      .dn_rdy   (r[i+1]),
      .v        (v[i]),
      .d        (d[i])
    );
  end

  // r[i] = !v[i] | r[i+1], rippled from the consumer end through a local accumulator.
  always_comb begin : ready_chain
    logic acc;
    acc      = out_ready;
    r[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc  = acc | ~v[i];
      r[i] = acc;
    end
  end

  assign in_ready  = r[0] & ~flush;
  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_data  = d[DEPTH-1];
  assign in_acc    = in_valid & in_ready;
  assign out_acc   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else if (in_acc && !out_acc) begin
      count <= count + CW'(1);
    end else if (out_acc && !in_acc) begin
      count <= count - CW'(1);
    end
  end

endmodule
